// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : stall/forward scheduler and MDU busy sequencer for a 5-stage pipe
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] D_dst,
  input  logic       D_we,
  input  logic [1:0] D_tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_md_use,
  output logic       stall,
  output logic [1:0] fwd_D_rs,
  output logic [1:0] fwd_D_rt,
  output logic [1:0] fwd_E_rs,
  output logic [1:0] fwd_E_rt,
  output logic       md_busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_E   = 2'd1;
  localparam logic [1:0] SEL_M   = 2'd2;
  localparam logic [1:0] SEL_W   = 2'd3;

  // Pipeline shadow records
  logic [4:0]       e_rs_q, e_rs_d;
  logic [4:0]       e_rt_q, e_rt_d;
  logic [4:0]       e_dst_q, e_dst_d;
  logic             e_we_q, e_we_d;
  logic [1:0]       e_tnew_q, e_tnew_d;
  logic             e_md_q, e_md_d;
  logic             e_div_q, e_div_d;
  logic [4:0]       m_dst_q, m_dst_d;
  logic             m_we_q, m_we_d;
  logic [1:0]       m_tnew_q, m_tnew_d;
  logic [4:0]       w_dst_q, w_dst_d;
  logic             w_we_q, w_we_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  // A record only matches when it really writes a non-zero register.
  function automatic logic rec_hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt, w_hit_rs, w_hit_rt;
  logic me_hit_rs, me_hit_rt, we_hit_rs, we_hit_rt;

  always_comb begin
    e_hit_rs  = rec_hit(e_we_q, e_dst_q, D_rs);
    e_hit_rt  = rec_hit(e_we_q, e_dst_q, D_rt);
    m_hit_rs  = rec_hit(m_we_q, m_dst_q, D_rs);
    m_hit_rt  = rec_hit(m_we_q, m_dst_q, D_rt);
    w_hit_rs  = rec_hit(w_we_q, w_dst_q, D_rs);
    w_hit_rt  = rec_hit(w_we_q, w_dst_q, D_rt);
    me_hit_rs = rec_hit(m_we_q, m_dst_q, e_rs_q);
    me_hit_rt = rec_hit(m_we_q, m_dst_q, e_rt_q);
    we_hit_rs = rec_hit(w_we_q, w_dst_q, e_rs_q);
    we_hit_rt = rec_hit(w_we_q, w_dst_q, e_rt_q);
  end

  always_comb begin
    md_busy = (md_cnt_q != CNT_ZERO) || e_md_q;
    stall   = (e_hit_rs && (e_tnew_q > D_tuse_rs)) ||
              (e_hit_rt && (e_tnew_q > D_tuse_rt)) ||
              (m_hit_rs && (m_tnew_q > D_tuse_rs)) ||
              (m_hit_rt && (m_tnew_q > D_tuse_rt)) ||
              (D_md_use && md_busy);
  end

  always_comb begin
    fwd_D_rs = SEL_REG;
    if (e_hit_rs && (e_tnew_q == 2'd0))      fwd_D_rs = SEL_E;
    else if (m_hit_rs && (m_tnew_q == 2'd0)) fwd_D_rs = SEL_M;
    else if (w_hit_rs)                       fwd_D_rs = SEL_W;

    fwd_D_rt = SEL_REG;
    if (e_hit_rt && (e_tnew_q == 2'd0))      fwd_D_rt = SEL_E;
    else if (m_hit_rt && (m_tnew_q == 2'd0)) fwd_D_rt = SEL_M;
    else if (w_hit_rt)                       fwd_D_rt = SEL_W;

    // Readiness in E is guaranteed by the stall rules, so no tnew test here.
    fwd_E_rs = SEL_REG;
    if (me_hit_rs)      fwd_E_rs = SEL_M;
    else if (we_hit_rs) fwd_E_rs = SEL_W;

    fwd_E_rt = SEL_REG;
    if (me_hit_rt)      fwd_E_rt = SEL_M;
    else if (we_hit_rt) fwd_E_rt = SEL_W;
  end

  always_comb begin
    w_dst_d  = m_dst_q;
    w_we_d   = m_we_q;

    m_dst_d  = e_dst_q;
    m_we_d   = e_we_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : (e_tnew_q - 2'd1);

    e_rs_d   = D_rs;
    e_rt_d   = D_rt;
    e_dst_d  = D_dst;
    e_we_d   = D_we;
    e_tnew_d = D_tnew;
    e_md_d   = D_md_start;
    e_div_d  = D_md_start && D_md_div;

    if (flush) begin
      m_dst_d  = 5'd0;
      m_we_d   = 1'b0;
      m_tnew_d = 2'd0;
    end

    if (flush || stall) begin
      e_rs_d   = 5'd0;
      e_rt_d   = 5'd0;
      e_dst_d  = 5'd0;
      e_we_d   = 1'b0;
      e_tnew_d = 2'd0;
      e_md_d   = 1'b0;
      e_div_d  = 1'b0;
    end

    // An MDU op already in E keeps running through a flush.
    md_cnt_d = md_cnt_q;
    if (e_md_q)                     md_cnt_d = e_div_q ? CNT_DIV : CNT_MULT;
    else if (md_cnt_q != CNT_ZERO)  md_cnt_d = md_cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      e_dst_q  <= 5'd0;
      e_we_q   <= 1'b0;
      e_tnew_q <= 2'd0;
      e_md_q   <= 1'b0;
      e_div_q  <= 1'b0;
      m_dst_q  <= 5'd0;
      m_we_q   <= 1'b0;
      m_tnew_q <= 2'd0;
      w_dst_q  <= 5'd0;
      w_we_q   <= 1'b0;
      md_cnt_q <= CNT_ZERO;
    end else begin
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_dst_q  <= e_dst_d;
      e_we_q   <= e_we_d;
      e_tnew_q <= e_tnew_d;
      e_md_q   <= e_md_d;
      e_div_q  <= e_div_d;
      m_dst_q  <= m_dst_d;
      m_we_q   <= m_we_d;
      m_tnew_q <= m_tnew_d;
      w_dst_q  <= w_dst_d;
      w_we_q   <= w_we_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed scenario bench for hazard_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic [4:0] D_rs, D_rt, D_dst;
  logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
  logic       D_we, D_md_start, D_md_div, D_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_dst(D_dst), .D_we(D_we), .D_tnew(D_tnew),
    .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
    .stall(stall), .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
    .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                       input logic [4:0] dst, input logic we, input logic [1:0] tnew,
                       input logic mds, input logic mdd, input logic mdu);
    D_rs = rs; D_rt = rt; D_tuse_rs = tu_rs; D_tuse_rt = tu_rt;
    D_dst = dst; D_we = we; D_tnew = tnew;
    D_md_start = mds; D_md_div = mdd; D_md_use = mdu;
    #1;
  endtask

  task automatic nop_drain();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    flush   = 1'b0;
    repeat (2) begin
      set_d(5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom), 5'($urandom),
            1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    reset_n = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", stall); end
    checks++; if (fwd_D_rs !== 2'd0) begin errors++; $display("FAIL rst_fwd_D_rs got %0d exp 0", fwd_D_rs); end
    checks++; if (fwd_D_rt !== 2'd0) begin errors++; $display("FAIL rst_fwd_D_rt got %0d exp 0", fwd_D_rt); end
    checks++; if (fwd_E_rs !== 2'd0) begin errors++; $display("FAIL rst_fwd_E_rs got %0d exp 0", fwd_E_rs); end
    checks++; if (fwd_E_rt !== 2'd0) begin errors++; $display("FAIL rst_fwd_E_rt got %0d exp 0", fwd_E_rt); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy got %0b exp 0", md_busy); end
  endtask

  // lw $8,0($29) then addu $10,$8,$9
  task automatic test_load_use();
    nop_drain();
    set_d(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_lw_in_d got %0b exp 0", stall); end
    tick();
    set_d(5'd8, 5'd9, 2'd1, 2'd1, 5'd10, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b exp 1", stall); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_end got %0b exp 0", stall); end
    checks++; if (fwd_D_rs !== 2'd0) begin errors++; $display("FAIL lu_fwd_D_rs_m got %0d exp 0", fwd_D_rs); end
    tick();
    set_d(5'd8, 5'd0, 2'd1, 2'd3, 5'd11, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    checks++; if (fwd_E_rs !== 2'd3) begin errors++; $display("FAIL lu_fwd_E_rs got %0d exp 3", fwd_E_rs); end
    checks++; if (fwd_E_rt !== 2'd0) begin errors++; $display("FAIL lu_fwd_E_rt got %0d exp 0", fwd_E_rt); end
    checks++; if (fwd_D_rs !== 2'd3) begin errors++; $display("FAIL lu_fwd_D_rs_w got %0d exp 3", fwd_D_rs); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_later_stall got %0b exp 0", stall); end
  endtask

  // addu $5 ; addu $6,$5 ; beq $5
  task automatic test_back_to_back();
    nop_drain();
    set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd5, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd5, 5'd2, 2'd1, 2'd1, 5'd6, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %0b exp 0", stall); end
    checks++; if (fwd_D_rs !== 2'd0) begin errors++; $display("FAIL b2b_fwd_D_rs got %0d exp 0", fwd_D_rs); end
    tick();
    set_d(5'd5, 5'd6, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (fwd_E_rs !== 2'd2) begin errors++; $display("FAIL b2b_fwd_E_rs got %0d exp 2", fwd_E_rs); end
    checks++; if (fwd_D_rs !== 2'd2) begin errors++; $display("FAIL b2b_beq_fwd_D_rs got %0d exp 2", fwd_D_rs); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_beq_stall got %0b exp 1", stall); end
  endtask

  // jal in E, beq $31,$0 in D
  task automatic test_jal();
    nop_drain();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd31, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jal_stall got %0b exp 0", stall); end
    checks++; if (fwd_D_rs !== 2'd1) begin errors++; $display("FAIL jal_fwd_D_rs got %0d exp 1", fwd_D_rs); end
    checks++; if (fwd_D_rt !== 2'd0) begin errors++; $display("FAIL jal_fwd_D_rt got %0d exp 0", fwd_D_rt); end
  endtask

  task automatic test_zero_dst();
    nop_drain();
    set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %0b exp 0", stall); end
    checks++; if (fwd_D_rs !== 2'd0) begin errors++; $display("FAIL zero_fwd_D_rs got %0d exp 0", fwd_D_rs); end
  endtask

  task automatic test_mdu(input logic is_div, input int exp_cycles);
    int n;
    nop_drain();
    set_d(5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1, is_div, 1'b1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL md_start_stall div=%0b got %0b exp 0", is_div, stall); end
    tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL md_busy_e div=%0b got %0b exp 1", is_div, md_busy); end
    n = 0;
    while (stall === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++; if (n != exp_cycles) begin errors++; $display("FAIL md_stall_len div=%0b got %0d exp %0d", is_div, n, exp_cycles); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL md_busy_end div=%0b got %0b exp 0", is_div, md_busy); end
  endtask

  // addu $3 ; lw $9 ; addu $?,$9 with flush while lw is in E
  task automatic test_flush();
    nop_drain();
    set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd29, 5'd0, 2'd1, 2'd3, 5'd9, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd9, 5'd0, 2'd0, 2'd3, 5'd12, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fl_pre_stall got %0b exp 1", stall); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_post_stall got %0b exp 0", stall); end
    checks++; if (fwd_D_rs !== 2'd0) begin errors++; $display("FAIL fl_fwd_D_rs9 got %0d exp 0", fwd_D_rs); end
    set_d(5'd3, 5'd9, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (fwd_D_rs !== 2'd3) begin errors++; $display("FAIL fl_w_kept got %0d exp 3", fwd_D_rs); end
    checks++; if (fwd_D_rt !== 2'd0) begin errors++; $display("FAIL fl_fwd_D_rt9 got %0d exp 0", fwd_D_rt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_m_empty got %0b exp 0", stall); end
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    test_reset();
    test_load_use();
    test_back_to_back();
    test_jal();
    test_zero_dst();
    test_mdu(1'b0, 5);
    test_mdu(1'b1, 10);
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
